led_pattern_gen: RTL and testbench

//  Multi-channel LED pattern generator; parametrised successor to the free-running LED blinker.
//  A shared prescaler produces a slow tick. Each channel has its own mode, period, duty and phase counter.

---
 rtl/led_pattern_gen.sv | 138 +++++++++++++
 tb/tb_led_pattern_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: a shared prescaler tick advances a
// per-channel phase counter that drives OFF/ON/PWM/ONESHOT LED patterns.
module led_pattern_gen #(
  parameter int NUM_CH   = 4,
  parameter int PRESCALE = 100000,
  parameter int CNT_W    = 8,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [1:0]          cfg_mode,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_duty,
  output logic                tick,
  output logic [NUM_CH-1:0]   leds,
  output logic [NUM_CH-1:0]   os_done,
  output logic [2*NUM_CH-1:0] dbg_mode
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_ON      = 2'b01,
    MODE_PWM     = 2'b10,
    MODE_ONESHOT = 2'b11
  } mode_e;

  logic [PRE_W-1:0]  pre_cnt_q, pre_cnt_d;
  logic              tick_q, tick_d;
  mode_e             mode_q   [NUM_CH];
  mode_e             mode_d   [NUM_CH];
  logic [CNT_W-1:0]  period_q [NUM_CH];
  logic [CNT_W-1:0]  period_d [NUM_CH];
  logic [CNT_W-1:0]  duty_q   [NUM_CH];
  logic [CNT_W-1:0]  duty_d   [NUM_CH];
  logic [CNT_W-1:0]  ph_q     [NUM_CH];
  logic [CNT_W-1:0]  ph_d     [NUM_CH];
  logic [NUM_CH-1:0] leds_q, leds_d;
  logic [NUM_CH-1:0] os_done_q, os_done_d;

  // Config port is a one-cycle strobe with no back-pressure: every edge with
  // cfg_we=1 and an in-range cfg_ch is a completed write; out-of-range is dropped.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    tick_d    = 1'b0;
    leds_d    = '0;
    os_done_d = '0;
    if (enable) begin
      if (pre_cnt_q == PRE_W'(PRESCALE - 1)) begin
        pre_cnt_d = '0;
        tick_d    = 1'b1;
      end else begin
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
      end
    end

    for (int i = 0; i < NUM_CH; i++) begin
      mode_d[i]   = mode_q[i];
      period_d[i] = period_q[i];
      duty_d[i]   = duty_q[i];
      ph_d[i]     = ph_q[i];

      // LED reflects the state before this edge, giving one clock of latency.
      unique case (mode_q[i])
        MODE_OFF:     leds_d[i] = 1'b0;
        MODE_ON:      leds_d[i] = 1'b1;
        MODE_PWM:     leds_d[i] = (ph_q[i] < duty_q[i]);
        MODE_ONESHOT: leds_d[i] = (ph_q[i] < duty_q[i]);
        default:      leds_d[i] = 1'b0;
      endcase

      // A write always beats a coincident tick on the same channel.
      if (cfg_we && (32'(cfg_ch) == i)) begin
        mode_d[i]   = mode_e'(cfg_mode);
        period_d[i] = cfg_period;
        duty_d[i]   = cfg_duty;
        ph_d[i]     = '0;
      end else if (tick_q) begin
        unique case (mode_q[i])
          MODE_PWM: begin
            ph_d[i] = (ph_q[i] == period_q[i]) ? '0 : ph_q[i] + CNT_W'(1);
          end
          MODE_ONESHOT: begin
            if (({1'b0, ph_q[i]} + (CNT_W+1)'(1)) >= {1'b0, duty_q[i]}) begin
              mode_d[i]    = MODE_OFF;
              ph_d[i]      = '0;
              os_done_d[i] = 1'b1;
            end else begin
              ph_d[i] = ph_q[i] + CNT_W'(1);
            end
          end
          default: ph_d[i] = ph_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
      tick_q    <= 1'b0;
      leds_q    <= '0;
      os_done_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i]   <= MODE_OFF;
        period_q[i] <= '0;
        duty_q[i]   <= '0;
        ph_q[i]     <= '0;
      end
    end else begin
      pre_cnt_q <= pre_cnt_d;
      tick_q    <= tick_d;
      leds_q    <= leds_d;
      os_done_q <= os_done_d;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i]   <= mode_d[i];
        period_q[i] <= period_d[i];
        duty_q[i]   <= duty_d[i];
        ph_q[i]     <= ph_d[i];
      end
    end
  end

  always_comb begin
    dbg_mode = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      dbg_mode[2*i +: 2] = mode_q[i];
    end
  end

  assign tick    = tick_q;
  assign leds    = leds_q;
  assign os_done = os_done_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed scenarios plus random traffic, checked
// against a tick-level behavioural model through an expected queue.
module tb_led_pattern_gen;

  localparam int NCH = 3;
  localparam int PRE = 4;
  localparam int CW  = 8;
  localparam int W   = 2*NCH + 2*NCH + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          we = 1'b0;
  logic [1:0]    ch = '0;
  logic [1:0]    md = '0;
  logic [CW-1:0] per = '0;
  logic [CW-1:0] dty = '0;
  logic          tick;
  logic [NCH-1:0]   leds;
  logic [NCH-1:0]   os_done;
  logic [2*NCH-1:0] dbg_mode;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  // model state: mode 0 OFF, 1 ON, 2 PWM, 3 ONESHOT
  int m_mode [NCH];
  int m_per  [NCH];
  int m_duty [NCH];
  int m_ph   [NCH];
  bit m_tick;
  int en_edges;

  led_pattern_gen #(.NUM_CH(NCH), .PRESCALE(PRE), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(en), .cfg_we(we), .cfg_ch(ch),
    .cfg_mode(md), .cfg_period(per), .cfg_duty(dty),
    .tick(tick), .leds(leds), .os_done(os_done), .dbg_mode(dbg_mode)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit led_of(int i);
    case (m_mode[i])
      1:       return 1'b1;
      2, 3:    return m_ph[i] < m_duty[i];
      default: return 1'b0;
    endcase
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_mode[i] = 0; m_per[i] = 0; m_duty[i] = 0; m_ph[i] = 0;
    end
    m_tick   = 1'b0;
    en_edges = 0;
  endfunction

  // One clock edge of the model; pushes the outputs expected after it.
  function automatic void model_edge();
    logic [NCH-1:0]   n_leds = '0;
    logic [NCH-1:0]   n_os   = '0;
    logic [2*NCH-1:0] n_mode = '0;
    bit n_tick;
    for (int i = 0; i < NCH; i++) n_leds[i] = led_of(i);
    for (int i = 0; i < NCH; i++) begin
      if (we && int'(ch) == i) begin
        m_mode[i] = int'(md); m_per[i] = int'(per); m_duty[i] = int'(dty); m_ph[i] = 0;
      end else if (m_tick) begin
        if (m_mode[i] == 2) begin
          m_ph[i] = (m_ph[i] == m_per[i]) ? 0 : m_ph[i] + 1;
        end else if (m_mode[i] == 3) begin
          if (m_ph[i] + 1 >= m_duty[i]) begin
            m_mode[i] = 0; m_ph[i] = 0; n_os[i] = 1'b1;
          end else begin
            m_ph[i] = m_ph[i] + 1;
          end
        end
      end
      n_mode[2*i +: 2] = 2'(m_mode[i]);
    end
    n_tick = 1'b0;
    if (en) begin
      en_edges++;
      n_tick = (en_edges % PRE) == 0;
    end
    m_tick = n_tick;
    exp_q.push_back({n_mode, n_os, n_leds, n_tick});
  endfunction

  task automatic compare_outputs();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check("tick",     32'(tick),     32'(e[0]));
    check("leds",     32'(leds),     32'(e[NCH:1]));
    check("os_done",  32'(os_done),  32'(e[2*NCH:NCH+1]));
    check("dbg_mode", 32'(dbg_mode), 32'(e[W-1:2*NCH+1]));
  endtask

  // driver: apply inputs on the falling edge, sample #1 after the rising edge
  task automatic step(input logic e_i, input logic we_i, input logic [1:0] ch_i,
                      input logic [1:0] md_i, input int per_i, input int dty_i);
    @(negedge clk);
    en = e_i; we = we_i; ch = ch_i; md = md_i; per = CW'(per_i); dty = CW'(dty_i);
    @(posedge clk);
    model_edge();
    #1 compare_outputs();
  endtask

  task automatic idle(input int n, input logic e_i);
    for (int k = 0; k < n; k++) step(e_i, 1'b0, 2'd0, 2'd0, 0, 0);
  endtask

  task automatic write(input logic [1:0] ch_i, input logic [1:0] md_i, input int per_i, input int dty_i);
    step(1'b1, 1'b1, ch_i, md_i, per_i, dty_i);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; we = 1'b0; en = 1'b0;
    #1;
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_os",   32'(os_done), 32'd0);
    check("rst_mode", 32'(dbg_mode), 32'd0);
    model_reset();
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("rst_hold_leds", 32'(leds), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    apply_reset();
    idle(6, 1'b1);

    // PWM period 3 duty 2 on ch0, ONESHOT duty 3 on ch1
    write(2'd0, 2'b10, 3, 2);
    idle(40, 1'b1);
    write(2'd1, 2'b11, 0, 3);
    idle(24, 1'b1);

    // out-of-range channel write must change nothing
    write(2'd3, 2'b01, 5, 5);
    idle(6, 1'b1);

    // write ch0 on the edge where a tick is being consumed
    for (int k = 0; k < 3*PRE && !m_tick; k++) idle(1, 1'b1);
    check("tick_found", 32'(m_tick), 32'd1);
    write(2'd0, 2'b10, 1, 1);
    idle(20, 1'b1);

    // duty>period always on, duty 0 always off, static ON/OFF
    write(2'd0, 2'b10, 3, 9);
    write(2'd1, 2'b10, 3, 0);
    write(2'd2, 2'b01, 0, 0);
    idle(20, 1'b1);
    write(2'd2, 2'b00, 0, 0);
    idle(4, 1'b1);

    // freeze mid-PWM, then resume
    write(2'd0, 2'b10, 3, 2);
    idle(9, 1'b1);
    idle(20, 1'b0);
    idle(20, 1'b1);

    // reset mid-PWM, then restart
    apply_reset();
    idle(PRE + 2, 1'b1);
    write(2'd2, 2'b10, 2, 1);
    idle(12, 1'b1);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0,
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           $urandom_range(0, 5), $urandom_range(0, 7));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
